// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, async ROM addressing and a prefetch FIFO toward decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise a sticky misaligned flag.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic {FETCH, HALT} state_t;
    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [PW:0]   count;
    logic          pop, push;
    assign rom_addr   = fetch_pc[ADDR_W+1:2];
    assign inst_valid = count != '0;
    assign inst       = inst_valid ? mem_inst[rd] : 32'h00000013;
    assign inst_pc    = inst_valid ? mem_pc[rd] : 32'h0;
    assign pop        = inst_valid & inst_ready;
    assign push       = !redirect_valid && (count != FULL || pop) && state == FETCH;
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd       <= '0;
            wr       <= '0;
            count    <= '0;
            state    <= FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else if (redirect_valid) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_pc   <= redirect_pc;
                state      <= HALT;
                misaligned <= 1'b1;
            end else begin
                fetch_pc   <= redirect_pc;
                state      <= FETCH;
                misaligned <= 1'b0;
            end
`else
            fetch_pc <= {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (push) begin
                mem_pc[wr]   <= fetch_pc;
                mem_inst[wr] <= rom_data;
                wr           <= wr + 1'b1;
                fetch_pc     <= fetch_pc + 32'd4;
            end
            if (pop) rd <= rd + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule
